// File: rtl/jellyvl_etherneco_pkg.sv
// Shared types for the Etherneco tx arbiter: FSM states and one-hot grant codes.
package jellyvl_etherneco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/jellyvl_etherneco_gap_timer.sv
// Inter-frame gap down-counter: load a start value, count down to zero, flag done at zero.
module jellyvl_etherneco_gap_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/jellyvl_etherneco_tx_arbiter.sv
// Two-source frame arbiter onto a shared tx stream with inter-frame gap.
// Optional statistics counters enabled by JELLYVL_ETHERNECO_TX_ARBITER_STATS_EN.
module jellyvl_etherneco_tx_arbiter
  import jellyvl_etherneco_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 12,
  parameter int unsigned GAP_WIDTH   = 8,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  s0_first,
  input  logic                  s0_last,
  input  logic [7:0]            s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,

  input  logic                  s1_first,
  input  logic                  s1_last,
  input  logic [7:0]            s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,

  output logic                  m_first,
  output logic                  m_last,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,

  output logic                  busy,
  output logic [1:0]            grant,
  output logic [STAT_WIDTH-1:0] stat_frame0,
  output logic [STAT_WIDTH-1:0] stat_frame1,
  output logic [STAT_WIDTH-1:0] stat_drop
);

  localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
    GAP_WIDTH'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] grant_next;
  logic       last_s1;
  logic       last_s1_next;
  logic       pick_s1;
  logic       req0;
  logic       req1;
  logic       drop0;
  logic       drop1;
  logic       frame_end;
  logic       gap_load;
  logic       gap_done;

  assign req0 = s0_valid && s0_first;
  assign req1 = s1_valid && s1_first;
  assign busy = (state != ST_IDLE);

  // last_s1 resets high so s0 wins the first contested arbitration
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      grant   <= GRANT_NONE;
      last_s1 <= 1'b1;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      last_s1 <= last_s1_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    last_s1_next = last_s1;
    pick_s1      = 1'b0;
    m_valid      = 1'b0;
    m_first      = 1'b0;
    m_last       = 1'b0;
    m_data       = '0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    drop0        = 1'b0;
    drop1        = 1'b0;
    frame_end    = 1'b0;
    gap_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          pick_s1      = req1 && (!req0 || ((ROUND_ROBIN != 0) && !last_s1));
          grant_next   = pick_s1 ? GRANT_S1 : GRANT_S0;
          last_s1_next = pick_s1;
          state_next   = ST_GRANT;
        end else begin
          // no start-of-frame pending: any presented beat is a stray and is discarded
          drop0    = s0_valid && reset;
          drop1    = s1_valid && reset;
          s0_ready = drop0;
          s1_ready = drop1;
        end
      end

      ST_GRANT: begin
        // handshakes are suppressed while reset is low so an abandoned frame never closes
        if (grant == GRANT_S1) begin
          m_valid  = s1_valid && reset;
          m_first  = s1_first;
          m_last   = s1_last;
          m_data   = s1_data;
          s1_ready = m_ready && reset;
        end else begin
          m_valid  = s0_valid && reset;
          m_first  = s0_first;
          m_last   = s0_last;
          m_data   = s0_data;
          s0_ready = m_ready && reset;
        end
        if (m_valid && m_ready && m_last) begin
          frame_end  = 1'b1;
          grant_next = GRANT_NONE;
          if (GAP_CYCLES != 0) begin
            gap_load   = 1'b1;
            state_next = ST_GAP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (gap_done) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = GRANT_NONE;
      end
    endcase
  end

  jellyvl_etherneco_gap_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (gap_load),
    .load_value(GAP_LOAD),
    .done      (gap_done)
  );

`ifdef JELLYVL_ETHERNECO_TX_ARBITER_STATS_EN
  logic [STAT_WIDTH-1:0] frame0_cnt;
  logic [STAT_WIDTH-1:0] frame1_cnt;
  logic [STAT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame0_cnt <= '0;
      frame1_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (frame_end && (grant == GRANT_S0)) frame0_cnt <= frame0_cnt + STAT_WIDTH'(1);
      if (frame_end && (grant == GRANT_S1)) frame1_cnt <= frame1_cnt + STAT_WIDTH'(1);
      drop_cnt <= drop_cnt + STAT_WIDTH'(drop0) + STAT_WIDTH'(drop1);
    end
  end

  assign stat_frame0 = frame0_cnt;
  assign stat_frame1 = frame1_cnt;
  assign stat_drop   = drop_cnt;
`else
  logic stats_unused;
  assign stats_unused = ^{drop0, drop1, frame_end};
  assign stat_frame0  = '0;
  assign stat_frame1  = '0;
  assign stat_drop    = '0;
`endif

endmodule

// File: tb/tb_jellyvl_etherneco_tx_arbiter.sv
// Self-checking bench for jellyvl_etherneco_tx_arbiter: IDLE vector table plus scoreboarded frame scenarios.
module tb_jellyvl_etherneco_tx_arbiter;
  import jellyvl_etherneco_pkg::*;

`ifdef JELLYVL_ETHERNECO_TX_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } beat_t;

  typedef struct {
    logic       s0v, s0f, s1v, s1f;
    logic       exp_r0, exp_r1;
    logic [1:0] exp_g;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic s0_first, s0_last, s0_valid, s0_ready;
  logic s1_first, s1_last, s1_valid, s1_ready;
  logic [7:0] s0_data, s1_data, m_data;
  logic m_first, m_last, m_valid, m_ready, busy;
  logic [1:0] grant;
  logic [31:0] stat_frame0, stat_frame1, stat_drop;

  logic f_s0_first, f_s0_last, f_s0_valid, f_s0_ready;
  logic f_s1_first, f_s1_last, f_s1_valid, f_s1_ready;
  logic [7:0] f_s0_data, f_s1_data, f_m_data;
  logic f_m_first, f_m_last, f_m_valid, f_m_ready, f_busy;
  logic [1:0] f_grant;
  logic [31:0] f_stat_frame0, f_stat_frame1, f_stat_drop;

  jellyvl_etherneco_tx_arbiter #(
    .GAP_CYCLES(12), .GAP_WIDTH(8), .ROUND_ROBIN(1), .STAT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_first(s0_first), .s0_last(s0_last), .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_first(s1_first), .s1_last(s1_last), .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .grant(grant),
    .stat_frame0(stat_frame0), .stat_frame1(stat_frame1), .stat_drop(stat_drop)
  );

  jellyvl_etherneco_tx_arbiter #(
    .GAP_CYCLES(0), .GAP_WIDTH(8), .ROUND_ROBIN(0), .STAT_WIDTH(32)
  ) dut_fp (
    .clk(clk), .reset(reset),
    .s0_first(f_s0_first), .s0_last(f_s0_last), .s0_data(f_s0_data), .s0_valid(f_s0_valid), .s0_ready(f_s0_ready),
    .s1_first(f_s1_first), .s1_last(f_s1_last), .s1_data(f_s1_data), .s1_valid(f_s1_valid), .s1_ready(f_s1_ready),
    .m_first(f_m_first), .m_last(f_m_last), .m_data(f_m_data), .m_valid(f_m_valid), .m_ready(f_m_ready),
    .busy(f_busy), .grant(f_grant),
    .stat_frame0(f_stat_frame0), .stat_frame1(f_stat_frame1), .stat_drop(f_stat_drop)
  );

  int checks = 0;
  int errors = 0;

  beat_t      q0[$];
  beat_t      q1[$];
  beat_t      exp_q[$];
  logic [1:0] exp_grant_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_first = 1'b0; s0_last = 1'b0; s0_data = 8'h00;
    s1_valid = 1'b0; s1_first = 1'b0; s1_last = 1'b0; s1_data = 8'h00;
    m_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic add_frame(input int src, input int len, input logic [7:0] base, input int mid_first);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = base + 8'(i);
      b.first = (i == 0) || (i == mid_first);
      b.last  = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
      exp_q.push_back(b);
    end
    exp_grant_q.push_back((src == 0) ? GRANT_S0 : GRANT_S1);
  endtask

  // Drives queued beats, checks every m_* handshake against the scoreboard
  task automatic run(input string tag, input int max_cycles, input bit toggle, output int first_m);
    int         cyc;
    logic [1:0] prev_grant;
    beat_t      e;
    cyc        = 0;
    first_m    = -1;
    prev_grant = grant;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
      @(negedge clk);
      if (q0.size() != 0) begin s0_valid = 1'b1; {s0_data, s0_first, s0_last} = q0[0]; end
      else begin s0_valid = 1'b0; s0_data = 8'h00; s0_first = 1'b0; s0_last = 1'b0; end
      if (q1.size() != 0) begin s1_valid = 1'b1; {s1_data, s1_first, s1_last} = q1[0]; end
      else begin s1_valid = 1'b0; s1_data = 8'h00; s1_first = 1'b0; s1_last = 1'b0; end
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (grant != GRANT_NONE && grant != prev_grant) begin
        if (exp_grant_q.size() == 0) chk({tag, " extra_grant"}, 32'(grant), 32'(GRANT_NONE));
        else chk({tag, " grant_order"}, 32'(grant), 32'(exp_grant_q.pop_front()));
      end
      if (grant == GRANT_S1) chk({tag, " s0_ready_held"}, 32'(s0_ready), 32'd0);
      if (grant == GRANT_S0) chk({tag, " s1_ready_held"}, 32'(s1_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (first_m < 0) first_m = cyc;
        if (exp_q.size() == 0) begin
          chk({tag, " unexpected_beat"}, 32'(m_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " data"},  32'(m_data),  32'(e.data));
          chk({tag, " first"}, 32'(m_first), 32'(e.first));
          chk({tag, " last"},  32'(m_last),  32'(e.last));
        end
      end
      if (s0_valid && s0_ready) void'(q0.pop_front());
      if (s1_valid && s1_ready) void'(q1.pop_front());
      prev_grant = grant;
      cyc++;
    end
    chk({tag, " drained"}, 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
    q0.delete(); q1.delete(); exp_q.delete(); exp_grant_q.delete();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (!busy) return;
    end
    chk({tag, " wait_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[9];

  initial begin
    int first_m;
    int gap;
    int gap_bad;
    int grants;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, GRANT_NONE};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, GRANT_NONE};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GRANT_NONE};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, GRANT_NONE};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, GRANT_S0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT_S1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, GRANT_S0};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRANT_S0};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT_S1};

    f_s0_valid = 1'b0; f_s0_first = 1'b0; f_s0_last = 1'b0; f_s0_data = 8'h00;
    f_s1_valid = 1'b0; f_s1_first = 1'b0; f_s1_last = 1'b0; f_s1_data = 8'h00;
    f_m_ready  = 1'b1;

    // Reset state, with a stray beat presented that must not be accepted
    reset = 1'b0;
    idle_inputs();
    s0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst s0_ready", 32'(s0_ready), 32'd0);
    chk("rst s1_ready", 32'(s1_ready), 32'd0);
    chk("rst stat_frame0", stat_frame0, 32'd0);
    chk("rst stat_drop", stat_drop, 32'd0);
    s0_valid = 1'b0;
    reset = 1'b1;

    // IDLE decision table: ready on strays, grant registered one cycle later
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s0_valid = vt[i].s0v; s0_first = vt[i].s0f; s0_data = 8'(i);
      s1_valid = vt[i].s1v; s1_first = vt[i].s1f; s1_data = 8'(i + 16);
      #1;
      chk($sformatf("vec%0d s0_ready", i), 32'(s0_ready), 32'(vt[i].exp_r0));
      chk($sformatf("vec%0d s1_ready", i), 32'(s1_ready), 32'(vt[i].exp_r1));
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vt[i].exp_g));
      do_reset();
    end

    // 4-beat s0 frame followed by exactly 12 gap cycles
    add_frame(0, 4, 8'h10, -1);
    run("single", 40, 1'b0, first_m);
    chk("single latency", 32'(first_m), 32'd1);
    gap = 0;
    gap_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      if (m_valid) gap_bad++;
      gap++;
    end
    chk("gap length", 32'(gap), 32'd12);
    chk("gap m_valid", 32'(gap_bad), 32'd0);
    chk("single stat_frame0", stat_frame0, STATS ? 32'd1 : 32'd0);

    // Two stray beats from s1 while idle
    q1.push_back('{data: 8'hE1, first: 1'b0, last: 1'b0});
    q1.push_back('{data: 8'hE2, first: 1'b0, last: 1'b1});
    run("stray", 10, 1'b0, first_m);
    @(negedge clk);
    #1;
    chk("stray stat_drop", stat_drop, STATS ? 32'd2 : 32'd0);
    chk("stray m_valid", 32'(m_valid), 32'd0);

    // Round-robin from reset, 3 frames each; one frame carries a mid-frame first flag
    do_reset();
    add_frame(0, 3, 8'h20, -1);
    add_frame(1, 2, 8'h40, -1);
    add_frame(0, 2, 8'h28, -1);
    add_frame(1, 5, 8'h48, 2);
    add_frame(0, 4, 8'h30, -1);
    add_frame(1, 1, 8'h50, -1);
    run("rr", 400, 1'b0, first_m);
    @(negedge clk);
    #1;
    chk("rr stat_frame0", stat_frame0, STATS ? 32'd3 : 32'd0);
    chk("rr stat_frame1", stat_frame1, STATS ? 32'd3 : 32'd0);

    // 6-beat s1 frame under a 1010 m_ready pattern
    add_frame(1, 6, 8'h60, -1);
    run("stall", 100, 1'b1, first_m);
    @(negedge clk);
    #1;
    chk("stall stat_frame1", stat_frame1, STATS ? 32'd4 : 32'd0);

    // Reset on beat 3 of a 5-beat frame, then a fresh frame
    wait_idle("midrst");
    @(negedge clk);
    s0_valid = 1'b1; s0_first = 1'b1; s0_last = 1'b0; s0_data = 8'h70;
    @(negedge clk);
    @(negedge clk);
    s0_first = 1'b0; s0_data = 8'h71;
    @(negedge clk);
    s0_data = 8'h72;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("midrst m_valid", 32'(m_valid), 32'd0);
    chk("midrst grant", 32'(grant), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst stat_frame1", stat_frame1, 32'd0);
    chk("midrst stat_drop", stat_drop, 32'd0);
    add_frame(1, 3, 8'h80, -1);
    run("postrst", 50, 1'b0, first_m);
    chk("postrst latency", 32'(first_m), 32'd1);
    @(negedge clk);
    #1;
    chk("postrst stat_frame1", stat_frame1, STATS ? 32'd1 : 32'd0);

    // Fixed priority, zero gap: s0 always wins against a permanently requesting s1
    do_reset();
    @(negedge clk);
    f_s0_valid = 1'b1; f_s0_first = 1'b1; f_s0_last = 1'b1; f_s0_data = 8'hA5;
    f_s1_valid = 1'b1; f_s1_first = 1'b1; f_s1_last = 1'b1; f_s1_data = 8'h5A;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("fp s1_ready", 32'(f_s1_ready), 32'd0);
      if (f_grant != GRANT_NONE) begin
        grants++;
        chk("fp grant", 32'(f_grant), 32'(GRANT_S0));
        chk("fp data", 32'(f_m_data), 32'h0000_00A5);
      end
    end
    @(posedge clk);
    #1;
    f_s0_valid = 1'b0;
    f_s1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("fp grant count", 32'(grants), 32'd10);
    chk("fp stat_frame0", f_stat_frame0, STATS ? 32'd10 : 32'd0);
    chk("fp stat_frame1", f_stat_frame1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
